// File: rtl/train_seq_pkg.sv
// Shared types for the training-pass sequencer: the FSM state enumeration and its encoding width.
// Latency: n/a (types only). Backpressure: n/a.
// Holds no logic.
package train_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ZERO_LOSS = 3'd1,
        ST_FWD       = 3'd2,
        ST_BWD       = 3'd3,
        ST_UPDATE    = 3'd4,
        ST_ZERO_WU   = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/train_seq_layer_ctr.sv
// Layer index counter: loads 0 and counts up or down. It also provides the terminal flags.
// Latency: the count updates 1 cycle after a command; the flags are combinational on the count.
// Backpressure: none; commands come already qualified by the caller's enable.
module layer_ctr #(
    parameter int NUM_LAYERS = 2,
    parameter int LAYER_W    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [LAYER_W-1:0] cnt_o,
    output logic               last_o,
    output logic               zero_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (load_i) begin
            cnt_o <= '0;
        end else if (up_i) begin
            cnt_o <= cnt_o + LAYER_W'(1);
        end else if (down_i) begin
            cnt_o <= cnt_o - LAYER_W'(1);
        end
    end

    assign last_o = (cnt_o == LAYER_W'(NUM_LAYERS - 1));
    assign zero_o = (cnt_o == '0);

endmodule

// File: rtl/train_seq.sv
// Training-pass sequencer: zero loss, forward over the layers, backward, update and zero the weight updates, once per epoch.
// Latency: the strobes are Moore outputs of registered state. Each phase advances 1 cycle after step_done_i is accepted.
// Backpressure: en_i low freezes everything. step_done_i holds FWD/BWD/UPDATE until the datapath finishes.
module train_seq
    import train_seq_pkg::*;
#(
    parameter int  NUM_LAYERS = 2,
    parameter int  EPOCH_W    = 8,
    localparam int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic [EPOCH_W-1:0] epochs_i,
    input  logic               step_done_i,
    input  logic               abort_i,
    output logic               zero_loss_o,
    output logic               fwd_pass_o,
    output logic               bwd_pass_o,
    output logic               update_o,
    output logic               zero_weight_update_o,
    output logic [LAYER_W-1:0] layer_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               busy_o,
    output logic               done_o
);

    state_t             state_q, state_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [EPOCH_W-1:0] limit_q, limit_d;
    logic [EPOCH_W-1:0] epoch_inc;
    logic               ld_layer, up_layer, dn_layer;
    logic               layer_last, layer_zero;

    layer_ctr #(
        .NUM_LAYERS (NUM_LAYERS),
        .LAYER_W    (LAYER_W)
    ) u_layer_ctr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (ld_layer),
        .up_i   (up_layer),
        .down_i (dn_layer),
        .cnt_o  (layer_o),
        .last_o (layer_last),
        .zero_o (layer_zero)
    );

    // The run ends on equality with the latched limit, so the count never has to wrap.
    assign epoch_inc = epoch_q + EPOCH_W'(1);

    always_comb begin
        state_d  = state_q;
        epoch_d  = epoch_q;
        limit_d  = limit_q;
        ld_layer = 1'b0;
        up_layer = 1'b0;
        dn_layer = 1'b0;
        if (en_i) begin
            if (abort_i) begin
                state_d  = ST_IDLE;
                ld_layer = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            limit_d = epochs_i;
                            epoch_d = '0;
                            state_d = (epochs_i == '0) ? ST_DONE : ST_ZERO_LOSS;
                        end
                    end
                    ST_ZERO_LOSS: begin
                        ld_layer = 1'b1;
                        state_d  = ST_FWD;
                    end
                    ST_FWD: begin
                        if (step_done_i) begin
                            if (layer_last) state_d = ST_BWD;
                            else            up_layer = 1'b1;
                        end
                    end
                    ST_BWD: begin
                        if (step_done_i) begin
                            if (layer_zero) state_d = ST_UPDATE;
                            else            dn_layer = 1'b1;
                        end
                    end
                    ST_UPDATE: begin
                        if (step_done_i) state_d = ST_ZERO_WU;
                    end
                    ST_ZERO_WU: begin
                        epoch_d = epoch_inc;
                        state_d = (epoch_inc == limit_q) ? ST_DONE : ST_ZERO_LOSS;
                    end
                    ST_DONE: state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            epoch_q <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            epoch_q <= epoch_d;
            limit_q <= limit_d;
        end
    end

    assign zero_loss_o          = (state_q == ST_ZERO_LOSS);
    assign fwd_pass_o           = (state_q == ST_FWD);
    assign bwd_pass_o           = (state_q == ST_BWD);
    assign update_o             = (state_q == ST_UPDATE);
    assign zero_weight_update_o = (state_q == ST_ZERO_WU);
    assign busy_o               = (state_q != ST_IDLE);
    assign done_o               = (state_q == ST_DONE);
    assign epoch_o              = epoch_q;

endmodule

// File: tb/tb_train_seq.sv
// Directed bench for train_seq: a 3-layer instance for the phase sequencing and a 1-layer instance for the long 255-epoch run.
module tb_train_seq;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_ZL   = 5'b10000;
    localparam logic [4:0] S_FWD  = 5'b01000;
    localparam logic [4:0] S_BWD  = 5'b00100;
    localparam logic [4:0] S_UPD  = 5'b00010;
    localparam logic [4:0] S_ZWU  = 5'b00001;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic       a_en, a_start, a_sd, a_abort;
    logic [7:0] a_epochs;
    logic       a_zl, a_fwd, a_bwd, a_upd, a_zwu, a_busy, a_done;
    logic [1:0] a_layer;
    logic [7:0] a_epoch;

    logic       b_en, b_start, b_sd, b_abort;
    logic [7:0] b_epochs;
    logic       b_zl, b_fwd, b_bwd, b_upd, b_zwu, b_busy, b_done;
    logic [0:0] b_layer;
    logic [7:0] b_epoch;

    int total  = 0;
    int passed = 0;

    train_seq #(.NUM_LAYERS(3), .EPOCH_W(8)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(a_en), .start_i(a_start),
        .epochs_i(a_epochs), .step_done_i(a_sd), .abort_i(a_abort),
        .zero_loss_o(a_zl), .fwd_pass_o(a_fwd), .bwd_pass_o(a_bwd),
        .update_o(a_upd), .zero_weight_update_o(a_zwu), .layer_o(a_layer),
        .epoch_o(a_epoch), .busy_o(a_busy), .done_o(a_done)
    );

    train_seq #(.NUM_LAYERS(1), .EPOCH_W(8)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(b_en), .start_i(b_start),
        .epochs_i(b_epochs), .step_done_i(b_sd), .abort_i(b_abort),
        .zero_loss_o(b_zl), .fwd_pass_o(b_fwd), .bwd_pass_o(b_bwd),
        .update_o(b_upd), .zero_weight_update_o(b_zwu), .layer_o(b_layer),
        .epoch_o(b_epoch), .busy_o(b_busy), .done_o(b_done)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Packed as {zl,fwd,bwd,upd,zwu,busy,done,layer[1:0],epoch[7:0]}.
    task automatic a_chk(input string tag, input logic [4:0] s, input logic [1:0] l,
                         input logic [7:0] ep, input logic busy, input logic done);
        chk(tag, {a_zl, a_fwd, a_bwd, a_upd, a_zwu, a_busy, a_done, a_layer, a_epoch},
                 {s, busy, done, l, ep});
    endtask

    // The step finishes on the second cycle, as a slow datapath would.
    task automatic advance(input string tag, input logic [4:0] s, input logic [1:0] l,
                           input logic [7:0] ep);
        a_sd = 1'b0;
        tick();
        a_sd = 1'b1;
        tick();
        a_sd = 1'b0;
        a_chk(tag, s, l, ep, 1'b1, 1'b0);
    endtask

    // The sequence starts in ZERO_LOSS and ends in ZERO_WU. The count shown there still holds the old value.
    task automatic run_epoch(input logic [7:0] ep);
        tick();
        a_chk("ep_fwd0", S_FWD, 2'd0, ep, 1'b1, 1'b0);
        advance("ep_fwd1", S_FWD, 2'd1, ep);
        advance("ep_fwd2", S_FWD, 2'd2, ep);
        advance("ep_bwd2", S_BWD, 2'd2, ep);
        advance("ep_bwd1", S_BWD, 2'd1, ep);
        advance("ep_bwd0", S_BWD, 2'd0, ep);
        advance("ep_upd",  S_UPD, 2'd0, ep);
        advance("ep_zwu",  S_ZWU, 2'd0, ep);
    endtask

    initial begin
        int c_zl, c_fwd, c_bwd, c_upd, c_zwu, c_done;
        logic finished;

        rst_i = 1'b1;
        a_en = 1'b0; a_start = 1'b1; a_sd = 1'b1; a_abort = 1'b0; a_epochs = 8'd5;
        b_en = 1'b0; b_start = 1'b0; b_sd = 1'b0; b_abort = 1'b0; b_epochs = 8'd0;
        tick();
        tick();
        a_chk("reset_a", S_NONE, 2'd0, 8'd0, 1'b0, 1'b0);
        chk("reset_b", {1'b0, b_zl, b_fwd, b_bwd, b_upd, b_zwu, b_busy, b_done, b_layer, b_epoch}, 17'd0);
        rst_i = 1'b0;
        a_start = 1'b0; a_sd = 1'b0; a_en = 1'b1;
        tick();
        a_chk("idle_after_reset", S_NONE, 2'd0, 8'd0, 1'b0, 1'b0);

        // Two epochs over three layers.
        a_epochs = 8'd2;
        a_start  = 1'b1;
        tick();
        a_start  = 1'b0;
        a_chk("r33_zl", S_ZL, 2'd0, 8'd0, 1'b1, 1'b0);
        run_epoch(8'd0);
        tick();
        a_chk("r33_zl_ep1", S_ZL, 2'd0, 8'd1, 1'b1, 1'b0);
        run_epoch(8'd1);
        tick();
        a_chk("r33_done", S_NONE, 2'd0, 8'd2, 1'b1, 1'b1);
        tick();
        a_chk("r33_idle", S_NONE, 2'd0, 8'd2, 1'b0, 1'b0);
        tick();
        a_chk("r33_hold", S_NONE, 2'd0, 8'd2, 1'b0, 1'b0);

        // A limit of zero goes straight to DONE and clears the count.
        a_epochs = 8'd0;
        a_start  = 1'b1;
        tick();
        a_start  = 1'b0;
        a_chk("r34_done", S_NONE, 2'd0, 8'd0, 1'b1, 1'b1);
        tick();
        a_chk("r34_idle", S_NONE, 2'd0, 8'd0, 1'b0, 1'b0);

        // Abort together with step_done in BWD layer 1 of the second epoch.
        a_epochs = 8'd3;
        a_start  = 1'b1;
        tick();
        a_start  = 1'b0;
        a_chk("r35_zl", S_ZL, 2'd0, 8'd0, 1'b1, 1'b0);
        run_epoch(8'd0);
        tick();
        a_chk("r35_zl1", S_ZL, 2'd0, 8'd1, 1'b1, 1'b0);
        tick();
        advance("r35_fwd1", S_FWD, 2'd1, 8'd1);
        advance("r35_fwd2", S_FWD, 2'd2, 8'd1);
        advance("r35_bwd2", S_BWD, 2'd2, 8'd1);
        advance("r35_bwd1", S_BWD, 2'd1, 8'd1);
        a_abort = 1'b1;
        a_sd    = 1'b1;
        tick();
        a_abort = 1'b0;
        a_sd    = 1'b0;
        a_chk("r35_abort_idle", S_NONE, 2'd0, 8'd1, 1'b0, 1'b0);
        tick();
        a_chk("r35_no_done", S_NONE, 2'd0, 8'd1, 1'b0, 1'b0);

        // Freeze with en_i low while step_done_i is held high.
        a_epochs = 8'd1;
        a_start  = 1'b1;
        tick();
        a_start  = 1'b0;
        a_chk("r36_zl", S_ZL, 2'd0, 8'd0, 1'b1, 1'b0);
        tick();
        advance("r36_fwd1", S_FWD, 2'd1, 8'd0);
        a_en = 1'b0;
        a_sd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            a_chk("r36_frozen", S_FWD, 2'd1, 8'd0, 1'b1, 1'b0);
        end
        a_en = 1'b1;
        tick();
        a_sd = 1'b0;
        a_chk("r36_resume", S_FWD, 2'd2, 8'd0, 1'b1, 1'b0);

        // Start is ignored while busy, then a reset arrives in UPDATE.
        advance("r37_bwd2", S_BWD, 2'd2, 8'd0);
        advance("r37_bwd1", S_BWD, 2'd1, 8'd0);
        advance("r37_bwd0", S_BWD, 2'd0, 8'd0);
        advance("r37_upd",  S_UPD, 2'd0, 8'd0);
        a_start = 1'b1;
        tick();
        a_chk("r37_start_busy", S_UPD, 2'd0, 8'd0, 1'b1, 1'b0);
        a_start = 1'b0;
        rst_i   = 1'b1;
        tick();
        rst_i   = 1'b0;
        a_chk("r37_reset", S_NONE, 2'd0, 8'd0, 1'b0, 1'b0);
        tick();
        a_chk("r37_post_reset", S_NONE, 2'd0, 8'd0, 1'b0, 1'b0);

        // One layer and the maximum limit, with step_done held high throughout.
        c_zl = 0; c_fwd = 0; c_bwd = 0; c_upd = 0; c_zwu = 0; c_done = 0;
        finished = 1'b0;
        b_en = 1'b1; b_sd = 1'b1; b_epochs = 8'd255; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!b_busy) begin
                finished = 1'b1;
                break;
            end
            c_zl   += int'(b_zl);
            c_fwd  += int'(b_fwd);
            c_bwd  += int'(b_bwd);
            c_upd  += int'(b_upd);
            c_zwu  += int'(b_zwu);
            c_done += int'(b_done);
            if (b_fwd && b_layer !== 1'b0) c_fwd += 1000;
            tick();
        end
        chk("r38_finished", {16'd0, finished}, 17'd1);
        chk("r38_zl",   17'(c_zl),   17'd255);
        chk("r38_fwd",  17'(c_fwd),  17'd255);
        chk("r38_bwd",  17'(c_bwd),  17'd255);
        chk("r38_upd",  17'(c_upd),  17'd255);
        chk("r38_zwu",  17'(c_zwu),  17'd255);
        chk("r38_done", 17'(c_done), 17'd1);
        chk("r38_epoch", {9'd0, b_epoch}, 17'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
